irq_queue_ctrl: RTL and testbench



---
 rtl/irq_pkg.sv | 10 +
 rtl/irq_queue_ctrl_if.sv | 31 +++
 rtl/irq_fifo.sv | 70 +++++++
 rtl/irq_queue_ctrl.sv | 85 ++++++++
 tb/tb_irq_queue_ctrl.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt queue front-end.
package irq_pkg;
    localparam int unsigned NSRC_DEF  = 7;
    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned IRQ_NONE  = 0;

    function automatic int unsigned id_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/irq_queue_ctrl_if.sv
// Request/queue signal bundle between the interrupt sources, the core and irq_queue_ctrl.
interface irq_queue_ctrl_if
    import irq_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
);
    localparam int unsigned IDW = id_width(NSRC);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;

    logic [NSRC-1:0] irq_src;
    logic [NSRC-1:0] irq_mask;
    logic            irq_en;
    logic            irq_ack;
    logic            clr_err;
    logic            irq_valid;
    logic [IDW-1:0]  irq_id;
    logic [CW-1:0]   q_count;
    logic [NSRC-1:0] pend;
    logic            merge_err;

    modport master (
        output irq_src, irq_mask, irq_en, irq_ack, clr_err,
        input  irq_valid, irq_id, q_count, pend, merge_err
    );

    modport slave (
        input  irq_src, irq_mask, irq_en, irq_ack, clr_err,
        output irq_valid, irq_id, q_count, pend, merge_err
    );
endinterface

// File: rtl/irq_fifo.sv
// ID queue with a registered head; rdata reads 0 whenever the queue is empty.
module irq_fifo #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] rdata_nxt;

    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign rd_nxt    = rd_ptr + PW'(1);
    assign count_nxt = count + CW'(do_push) - CW'(do_pop);

    // Next head: the entry behind the popped one, or the incoming word when it lands at the head.
    always_comb begin
        rdata_nxt = rdata;
        if (do_pop) begin
            if (count == CW'(1)) begin
                rdata_nxt = do_push ? wdata : '0;
            end else begin
                rdata_nxt = mem[rd_nxt];
            end
        end else if (do_push && empty) begin
            rdata_nxt = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            rdata  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_nxt;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            rdata <= rdata_nxt;
        end
    end
endmodule

// File: rtl/irq_queue_ctrl.sv
// Interrupt front-end: edge detect, pending/merge latches, round-robin arbiter feeding the ID queue.
module irq_queue_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NSRC  = NSRC_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    irq_queue_ctrl_if.slave  bus
);
    localparam int unsigned IDW = id_width(NSRC);
    localparam int unsigned LW  = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pend_q;
    logic            merge_q;
    logic [LW-1:0]   last;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] gnt_oh;
    logic            gnt_any;
    logic [LW-1:0]   gnt_idx;
    int unsigned     cand;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IDW-1:0]  push_id;

    assign rise = bus.irq_src & ~src_q;
    assign elig = bus.irq_en ? (pend_q & ~bus.irq_mask) : '0;

    // First eligible source at or after last+1, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = last;
        cand    = 0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand = (32'(last) + k) % NSRC;
            if (!gnt_any && elig[LW'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = LW'(cand);
            end
        end
    end

    assign pop     = bus.irq_ack & ~fifo_empty;
    assign push    = gnt_any & (~fifo_full | pop);
    assign gnt_oh  = push ? (NSRC'(1) << gnt_idx) : '0;
    assign push_id = IDW'(32'(gnt_idx) + 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q   <= '0;
            pend_q  <= '0;
            merge_q <= 1'b0;
            last    <= LW'(NSRC - 1);
        end else begin
            src_q   <= bus.irq_src;
            pend_q  <= (pend_q & ~gnt_oh) | rise;
            merge_q <= (|(rise & pend_q & ~gnt_oh)) | (merge_q & ~bus.clr_err);
            if (push) last <= gnt_idx;
        end
    end

    irq_fifo #(
        .WIDTH (IDW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_id),
        .rdata (bus.irq_id),
        .count (bus.q_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.irq_valid = ~fifo_empty;
    assign bus.pend      = pend_q;
    assign bus.merge_err = merge_q;
endmodule

// File: tb/tb_irq_queue_ctrl.sv
// Bench for irq_queue_ctrl: two instances (DEPTH 16 and 2) sharing stimulus, checked against a queue model.
module tb_irq_queue_ctrl;
    localparam int NS = 7;
    localparam int D0 = 16;
    localparam int D1 = 2;

    logic clk;
    logic rst;
    logic [NS-1:0] src, mask;
    logic en, ack, clr;

    int total = 0;
    int bad   = 0;

    irq_queue_ctrl_if #(.NSRC(NS), .DEPTH(D0)) bus0 ();
    irq_queue_ctrl_if #(.NSRC(NS), .DEPTH(D1)) bus1 ();

    assign bus0.irq_src = src;  assign bus1.irq_src = src;
    assign bus0.irq_mask = mask; assign bus1.irq_mask = mask;
    assign bus0.irq_en = en;    assign bus1.irq_en = en;
    assign bus0.irq_ack = ack;  assign bus1.irq_ack = ack;
    assign bus0.clr_err = clr;  assign bus1.clr_err = clr;

    irq_queue_ctrl #(.NSRC(NS), .DEPTH(D0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    irq_queue_ctrl #(.NSRC(NS), .DEPTH(D1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: pending bits plus an ordered list of queued IDs.
    int          mdepth [2];
    bit [NS-1:0] mpend  [2];
    bit [NS-1:0] mprev  [2];
    int          mlast  [2];
    bit          mmerge [2];
    int          mq     [2][64];
    int          mcnt   [2];

    task automatic model_step(input int d);
        bit [NS-1:0] rise;
        int g;
        bit popv, pushv, mrg;
        if (rst) begin
            mcnt[d] = 0; mpend[d] = '0; mprev[d] = '0; mlast[d] = NS - 1; mmerge[d] = 0;
            return;
        end
        rise = src & ~mprev[d];
        g = -1;
        if (en) begin
            for (int k = 1; k <= NS; k++) begin
                int i;
                i = (mlast[d] + k) % NS;
                if (g < 0 && mpend[d][i] && !mask[i]) g = i;
            end
        end
        popv  = ack && (mcnt[d] > 0);
        pushv = (g >= 0) && ((mcnt[d] < mdepth[d]) || popv);
        mrg = 0;
        for (int i = 0; i < NS; i++)
            if (rise[i] && mpend[d][i] && !(pushv && g == i)) mrg = 1;
        mmerge[d] = mrg || (mmerge[d] && !clr);
        if (popv) begin
            for (int j = 0; j < mcnt[d] - 1; j++) mq[d][j] = mq[d][j + 1];
            mcnt[d]--;
        end
        if (pushv) begin
            mq[d][mcnt[d]] = g + 1;
            mcnt[d]++;
            mlast[d] = g;
            mpend[d][g] = 1'b0;
        end
        mpend[d] = mpend[d] | rise;
        mprev[d] = src;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare(input int d);
        int v, id, cnt, p, m;
        if (d == 0) begin
            v = int'(bus0.irq_valid); id = int'(bus0.irq_id); cnt = int'(bus0.q_count);
            p = int'(bus0.pend); m = int'(bus0.merge_err);
        end else begin
            v = int'(bus1.irq_valid); id = int'(bus1.irq_id); cnt = int'(bus1.q_count);
            p = int'(bus1.pend); m = int'(bus1.merge_err);
        end
        check($sformatf("model d%0d valid", d), v, int'(mcnt[d] > 0));
        check($sformatf("model d%0d id", d), id, (mcnt[d] > 0) ? mq[d][0] : 0);
        check($sformatf("model d%0d count", d), cnt, mcnt[d]);
        check($sformatf("model d%0d pend", d), p, int'(mpend[d]));
        check($sformatf("model d%0d merge", d), m, int'(mmerge[d]));
    endtask

    // One clock: DUTs and model see the same inputs, outputs sampled 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare(0);
        compare(1);
    endtask

    typedef struct {
        bit rst; bit [NS-1:0] src; bit [NS-1:0] mask; bit en; bit ack; bit clr;
        bit valid; int id; int cnt; bit [NS-1:0] pend; bit merge;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit r, input bit [NS-1:0] s, input bit [NS-1:0] mk, input bit e,
                       input bit a, input bit c, input bit v, input int id, input int cnt,
                       input bit [NS-1:0] p, input bit m);
        vec_t x;
        x.rst = r; x.src = s; x.mask = mk; x.en = e; x.ack = a; x.clr = c;
        x.valid = v; x.id = id; x.cnt = cnt; x.pend = p; x.merge = m;
        tbl.push_back(x);
    endtask

    initial begin
        mdepth[0] = D0; mdepth[1] = D1;
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0; mpend[d] = '0; mprev[d] = '0; mlast[d] = NS - 1; mmerge[d] = 0;
        end
        rst = 1'b1; src = '0; mask = '0; en = 1'b1; ack = 1'b0; clr = 1'b0;

        //  rst src    mask   en ack clr | valid id cnt pend   merge
        add(1, 7'h00, 7'h00, 1, 0, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h04, 7'h00, 1, 0, 0,    0, 0, 0, 7'h04, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 3, 1, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);
        add(1, 7'h00, 7'h00, 1, 0, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h49, 7'h00, 1, 0, 0,    0, 0, 0, 7'h49, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 1, 1, 7'h48, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 1, 2, 7'h40, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 1, 3, 7'h00, 0);
        add(0, 7'h49, 7'h00, 1, 0, 0,    1, 1, 3, 7'h49, 0);
        add(1, 7'h00, 7'h00, 1, 0, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h02, 7'h02, 1, 0, 0,    0, 0, 0, 7'h02, 0);
        add(0, 7'h00, 7'h02, 1, 0, 0,    0, 0, 0, 7'h02, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 2, 1, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h10, 7'h10, 1, 0, 0,    0, 0, 0, 7'h10, 0);
        add(0, 7'h00, 7'h10, 1, 0, 0,    0, 0, 0, 7'h10, 0);
        add(0, 7'h10, 7'h10, 1, 0, 0,    0, 0, 0, 7'h10, 1);
        add(0, 7'h00, 7'h10, 1, 0, 1,    0, 0, 0, 7'h10, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 5, 1, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h01, 7'h00, 0, 0, 0,    0, 0, 0, 7'h01, 0);
        add(0, 7'h00, 7'h00, 0, 0, 0,    0, 0, 0, 7'h01, 0);
        add(0, 7'h00, 7'h00, 1, 0, 0,    1, 1, 1, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);
        add(0, 7'h10, 7'h10, 1, 0, 0,    0, 0, 0, 7'h10, 0);
        add(0, 7'h00, 7'h10, 1, 0, 0,    0, 0, 0, 7'h10, 0);
        add(0, 7'h10, 7'h10, 1, 0, 1,    0, 0, 0, 7'h10, 1);
        add(0, 7'h00, 7'h00, 1, 0, 1,    1, 5, 1, 7'h00, 0);
        add(0, 7'h00, 7'h00, 1, 1, 0,    0, 0, 0, 7'h00, 0);

        #1;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; src = tbl[i].src; mask = tbl[i].mask;
            en = tbl[i].en; ack = tbl[i].ack; clr = tbl[i].clr;
            cycle();
            check($sformatf("row%0d valid", i), int'(bus0.irq_valid), int'(tbl[i].valid));
            check($sformatf("row%0d id", i), int'(bus0.irq_id), tbl[i].id);
            check($sformatf("row%0d count", i), int'(bus0.q_count), tbl[i].cnt);
            check($sformatf("row%0d pend", i), int'(bus0.pend), int'(tbl[i].pend));
            check($sformatf("row%0d merge", i), int'(bus0.merge_err), int'(tbl[i].merge));
        end

        // DEPTH=2 instance: third grant waits in pend until an ack frees a slot.
        rst = 1'b1; src = '0; mask = '0; en = 1'b1; ack = 1'b0; clr = 1'b0;
        cycle();
        rst = 1'b0; src = 7'h07;
        cycle();
        check("d2 pend after edge", int'(bus1.pend), 7);
        src = '0;
        cycle();
        check("d2 count first push", int'(bus1.q_count), 1);
        cycle();
        check("d2 count full", int'(bus1.q_count), 2);
        check("d2 pend held", int'(bus1.pend), 4);
        cycle();
        check("d2 count stays full", int'(bus1.q_count), 2);
        check("d2 pend still held", int'(bus1.pend), 4);
        check("d2 head id", int'(bus1.irq_id), 1);
        ack = 1'b1;
        cycle();
        check("d2 count push+pop full", int'(bus1.q_count), 2);
        check("d2 head after pop", int'(bus1.irq_id), 2);
        check("d2 pend drained", int'(bus1.pend), 0);
        ack = 1'b0;

        // Randomized traffic, including resets mid-stream and long full stretches on the small queue.
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            src  = NS'($urandom_range(0, 127));
            mask = ($urandom_range(0, 3) == 0) ? NS'($urandom_range(0, 127)) : '0;
            en   = ($urandom_range(0, 9) != 0);
            ack  = ($urandom_range(0, 2) == 0);
            clr  = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
